qspi_reader: RTL and testbench

QSPI_READER -- requirements
Module: qspi_reader

---
 rtl/qspi_reader.sv | 163 ++++++++++++++++
 tb/tb_qspi_reader.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/qspi_reader.sv
// Quad-output fast-read master: opcode and address go out on IO0, then nibbles are read on IO[3:0].
// Data phase L cycles stretch while fifo_full is high; stop ends the read cleanly at the next L entry.
module qspi_reader #(
    parameter int         DUMMY_CYCLES = 8,
    parameter logic [7:0] CMD          = 8'h6B
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [23:0] addr,
    input  logic        stop,
    input  logic        fifo_full,
    output logic        push,
    output logic [3:0]  push_data,
    output logic        busy,
    output logic        spi_cs_n,
    output logic        spi_sck,
    output logic [3:0]  spi_io_out,
    output logic [3:0]  spi_io_oe,
    input  logic [3:0]  spi_io_in
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_ADDR,
        S_DUMMY,
        S_DATA,
        S_FINISH
    } state_t;

    state_t      state_q, state_d;
    logic        phase_q, phase_d;      // 0 = L (sck low), 1 = H (sck high)
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] shift_q, shift_d;
    logic        stop_q, stop_d;
    logic        push_q, push_d;
    logic [3:0]  push_data_q, push_data_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            phase_q     <= 1'b0;
            cnt_q       <= '0;
            shift_q     <= '0;
            stop_q      <= 1'b0;
            push_q      <= 1'b0;
            push_data_q <= '0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            cnt_q       <= cnt_d;
            shift_q     <= shift_d;
            stop_q      <= stop_d;
            push_q      <= push_d;
            push_data_q <= push_data_d;
        end
    end

    logic stop_now;

    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        cnt_d       = cnt_q;
        shift_d     = shift_q;
        stop_d      = stop_q;
        push_d      = 1'b0;
        push_data_d = push_data_q;
        stop_now    = stop_q | stop;

        case (state_q)
            S_IDLE: begin
                stop_d = 1'b0;
                if (start && !stop) begin
                    state_d = S_CMD;
                    phase_d = 1'b0;
                    cnt_d   = '0;
                    shift_d = {CMD, addr};
                end
            end

            S_CMD, S_ADDR, S_DUMMY, S_DATA: begin
                if (!phase_q) begin
                    // A stalled data L phase has no pending edge, so stop can act at once.
                    if (state_q == S_DATA && fifo_full) begin
                        if (stop_now) begin
                            state_d = S_FINISH;
                            cnt_d   = '0;
                        end
                    end else begin
                        phase_d = 1'b1;
                        stop_d  = stop_now;
                    end
                end else begin
                    phase_d = 1'b0;
                    cnt_d   = cnt_q + 5'd1;
                    case (state_q)
                        S_CMD: begin
                            shift_d = {shift_q[30:0], 1'b0};
                            if (cnt_q == 5'd7) begin
                                state_d = S_ADDR;
                                cnt_d   = '0;
                            end
                        end
                        S_ADDR: begin
                            shift_d = {shift_q[30:0], 1'b0};
                            if (cnt_q == 5'd23) begin
                                state_d = S_DUMMY;
                                cnt_d   = '0;
                            end
                        end
                        S_DUMMY: begin
                            if (cnt_q == 5'(DUMMY_CYCLES - 1)) begin
                                state_d = S_DATA;
                                cnt_d   = '0;
                            end
                        end
                        default: begin
                            cnt_d       = cnt_q;
                            push_d      = 1'b1;
                            push_data_d = spi_io_in;
                        end
                    endcase
                    if (stop_now) begin
                        state_d = S_FINISH;
                        cnt_d   = '0;
                    end
                end
            end

            S_FINISH: begin
                stop_d  = 1'b0;
                phase_d = 1'b0;
                cnt_d   = cnt_q + 5'd1;
                if (cnt_q == 5'd1) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    logic active;
    logic tx_phase;

    always_comb begin
        active     = (state_q == S_CMD) || (state_q == S_ADDR) ||
                     (state_q == S_DUMMY) || (state_q == S_DATA);
        tx_phase   = (state_q == S_CMD) || (state_q == S_ADDR);
        busy       = (state_q != S_IDLE);
        spi_cs_n   = !active;
        spi_sck    = active && phase_q;
        spi_io_oe  = tx_phase ? 4'b1101 : 4'b0000;
        spi_io_out = tx_phase ? {3'b110, shift_q[31]} : 4'b0000;
        push       = push_q;
        push_data  = push_data_q;
    end

endmodule

// File: tb/tb_qspi_reader.sv
// Bench for qspi_reader: flash model on SCK, scoreboard of returned nibbles, timing table per read.
module tb_qspi_reader;

    localparam int         DUMMY = 8;
    localparam logic [3:0] D     = 4'b1101;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        fifo_full = 1'b0;
    logic [23:0] addr = '0;
    logic [3:0]  spi_io_in = '0;
    logic        push, busy, spi_cs_n, spi_sck;
    logic [3:0]  push_data, spi_io_out, spi_io_oe;

    qspi_reader #(.DUMMY_CYCLES(DUMMY), .CMD(8'h6B)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .addr(addr), .stop(stop),
        .fifo_full(fifo_full), .push(push), .push_data(push_data), .busy(busy),
        .spi_cs_n(spi_cs_n), .spi_sck(spi_sck), .spi_io_out(spi_io_out),
        .spi_io_oe(spi_io_oe), .spi_io_in(spi_io_in)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Flash model: captures IO0 on SCK rise, then presents a nibble on each data-phase rise.
    logic [3:0]  nib_tab [8] = '{4'hA, 4'h5, 4'hC, 4'h3, 4'h1, 4'hE, 4'h7, 4'h9};
    int          rise_cnt = 0;
    int          sck_rises = 0;
    logic [31:0] io0_cap = '0;
    logic [3:0]  exp_q [$];

    always @(posedge spi_sck or negedge spi_cs_n) begin
        if (spi_sck) begin
            sck_rises++;
            rise_cnt++;
            if (rise_cnt <= 32) begin
                io0_cap = {io0_cap[30:0], spi_io_out[0]};
            end else if (rise_cnt > 32 + DUMMY) begin
                spi_io_in = nib_tab[(rise_cnt - 33 - DUMMY) % 8];
                exp_q.push_back(spi_io_in);
            end
        end else begin
            rise_cnt = 0;
            io0_cap  = '0;
        end
    end

    int         push_cnt = 0;
    logic [3:0] exp_nib;

    always @(negedge clk) begin
        if (push === 1'b1) begin
            push_cnt++;
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL push_unexpected: got push data %0h expected no push (cycle %0d)", push_data, cyc);
            end else begin
                exp_nib = exp_q.pop_front();
                chk("push_data", push_data, exp_nib);
            end
        end
    end

    typedef struct {
        int         off;
        logic       cs_n;
        logic       sck;
        logic [3:0] oe;
        logic       busy;
        logic       push;
        logic [3:0] pd;
    } vec_t;

    vec_t tbl [14];
    int   t0 = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic begin_txn(input logic [23:0] a);
        addr  = a;
        start = 1'b1;
        t0    = cyc;
        tick();
        start = 1'b0;
    endtask

    task automatic run_to(input int off);
        while (cyc < t0 + off) tick();
    endtask

    task automatic do_stop();
        int c = 0;
        int r;
        stop = 1'b1;
        tick();
        stop = 1'b0;
        while (spi_cs_n !== 1'b1 && c < 3) begin
            tick();
            c++;
        end
        chk("stop_cs_latency", (c <= 1), 1);
        r = sck_rises;
        chk("stop_busy_c0", busy, 1);
        tick();
        chk("stop_busy_c1", busy, 1);
        chk("stop_sck_c1", spi_sck, 0);
        tick();
        chk("stop_busy_c2", busy, 0);
        repeat (4) tick();
        chk("stop_no_sck_edge", sck_rises, r);
        chk("stop_scoreboard_empty", exp_q.size(), 0);
    endtask

    task automatic run_basic(input logic [23:0] a);
        int p0 = push_cnt;
        chk("idle_busy_before", busy, 0);
        begin_txn(a);
        for (int off = 1; off <= 90; off++) begin
            run_to(off);
            start = (off == 10);
            foreach (tbl[i]) begin
                if (tbl[i].off == off) begin
                    chk($sformatf("tbl_cs_n@%0d", off), spi_cs_n, tbl[i].cs_n);
                    chk($sformatf("tbl_sck@%0d", off), spi_sck, tbl[i].sck);
                    chk($sformatf("tbl_oe@%0d", off), spi_io_oe, tbl[i].oe);
                    chk($sformatf("tbl_busy@%0d", off), busy, tbl[i].busy);
                    chk($sformatf("tbl_push@%0d", off), push, tbl[i].push);
                    if (tbl[i].push) chk($sformatf("tbl_pd@%0d", off), push_data, tbl[i].pd);
                end
            end
        end
        chk("io0_stream", io0_cap, {8'h6B, a});
        chk("basic_push_count", push_cnt - p0, 4);
        run_to(91);
        do_stop();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int p0;
        int r0;
        tbl[0]  = '{1,  1'b0, 1'b0, D,    1'b1, 1'b0, 4'h0};
        tbl[1]  = '{2,  1'b0, 1'b1, D,    1'b1, 1'b0, 4'h0};
        tbl[2]  = '{16, 1'b0, 1'b1, D,    1'b1, 1'b0, 4'h0};
        tbl[3]  = '{17, 1'b0, 1'b0, D,    1'b1, 1'b0, 4'h0};
        tbl[4]  = '{64, 1'b0, 1'b1, D,    1'b1, 1'b0, 4'h0};
        tbl[5]  = '{65, 1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 4'h0};
        tbl[6]  = '{80, 1'b0, 1'b1, 4'h0, 1'b1, 1'b0, 4'h0};
        tbl[7]  = '{81, 1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 4'h0};
        tbl[8]  = '{82, 1'b0, 1'b1, 4'h0, 1'b1, 1'b0, 4'h0};
        tbl[9]  = '{83, 1'b0, 1'b0, 4'h0, 1'b1, 1'b1, 4'hA};
        tbl[10] = '{84, 1'b0, 1'b1, 4'h0, 1'b1, 1'b0, 4'h0};
        tbl[11] = '{85, 1'b0, 1'b0, 4'h0, 1'b1, 1'b1, 4'h5};
        tbl[12] = '{87, 1'b0, 1'b0, 4'h0, 1'b1, 1'b1, 4'hC};
        tbl[13] = '{89, 1'b0, 1'b0, 4'h0, 1'b1, 1'b1, 4'h3};

        // Reset, then ten idle cycles.
        repeat (3) tick();
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("idle_cs_n", spi_cs_n, 1);
            chk("idle_sck", spi_sck, 0);
            chk("idle_oe", spi_io_oe, 0);
            chk("idle_busy", busy, 0);
            chk("idle_push", push, 0);
        end

        // Full read with a start pulse while busy (at T+10).
        run_basic(24'h123456);

        // Seven-cycle stall at the second data L phase.
        begin_txn(24'hABCDEF);
        run_to(83);
        fifo_full = 1'b1;
        for (int off = 83; off <= 90; off++) begin
            run_to(off);
            if (off == 90) fifo_full = 1'b0;
            chk($sformatf("stall_sck@%0d", off), spi_sck, 0);
            if (off > 83) chk($sformatf("stall_push@%0d", off), push, 0);
        end
        run_to(91);
        chk("stall_resume_sck", spi_sck, 1);
        run_to(92);
        chk("stall_resume_push", push, 1);
        chk("stall_resume_pd", push_data, 4'h5);
        run_to(95);
        do_stop();

        // Stop in the H phase at T+84: the sampled nibble is still delivered.
        p0 = push_cnt;
        begin_txn(24'h000010);
        run_to(84);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("stop84_cs_n", spi_cs_n, 1);
        chk("stop84_push", push, 1);
        chk("stop84_pd", push_data, 4'h5);
        r0 = sck_rises;
        tick();
        chk("stop84_busy_c1", busy, 1);
        tick();
        chk("stop84_busy_c2", busy, 0);
        repeat (3) tick();
        chk("stop84_no_sck_edge", sck_rises, r0);
        chk("stop84_push_count", push_cnt - p0, 2);

        // Stop during the address phase.
        p0 = push_cnt;
        begin_txn(24'h555555);
        run_to(30);
        do_stop();
        chk("stop_addr_no_push", push_cnt - p0, 0);

        // start together with stop in IDLE is ignored.
        start = 1'b1;
        stop  = 1'b1;
        tick();
        start = 1'b0;
        stop  = 1'b0;
        chk("startstop_busy", busy, 0);
        chk("startstop_cs_n", spi_cs_n, 1);
        tick();
        chk("startstop_busy2", busy, 0);

        // Reset asserted mid-transaction at T+40.
        begin_txn(24'h0F0F0F);
        run_to(20);
        start = 1'b1;
        tick();
        start = 1'b0;
        run_to(40);
        rst_n = 1'b0;
        tick();
        chk("rst_cs_n", spi_cs_n, 1);
        chk("rst_sck", spi_sck, 0);
        chk("rst_oe", spi_io_oe, 0);
        chk("rst_io_out", spi_io_out, 0);
        chk("rst_busy", busy, 0);
        chk("rst_push", push, 0);
        chk("rst_push_data", push_data, 0);
        rst_n = 1'b1;
        repeat (2) tick();

        // A fresh read after reset behaves as the first one.
        run_basic(24'h123456);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
